// File: rtl/cdr_pkg.sv
// Shared CDR definitions: default widths, decimation ratio encoding and the
// decimator FSM state type.
package cdr_pkg;

  localparam int VOTE_W   = 6;
  localparam int MAX_LOG2 = 5;

  typedef enum logic [1:0] {
    DEC_4  = 2'd0,
    DEC_8  = 2'd1,
    DEC_16 = 2'd2,
    DEC_32 = 2'd3
  } dec_ratio_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Window length in cycles for a given ratio code: 4 << code.
  function automatic int dec_win_len(input logic [1:0] sel);
    return 4 << sel;
  endfunction

endpackage

// File: rtl/vote_sat.sv
// Turns a window sum into the loop-filter vote: either the sum clamped to the
// signed VOTE_W range, or just its sign (+1/0/-1).
module vote_sat #(
  parameter int VOTE_W = 6,
  parameter int ACC_W  = 7
) (
  input  logic signed [ACC_W-1:0]  sum,
  input  logic                     maj_mode,
  output logic        [VOTE_W-1:0] vote
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (VOTE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (VOTE_W - 1)));

  logic is_neg;
  logic is_pos;

  assign is_neg = sum[ACC_W-1];
  assign is_pos = !sum[ACC_W-1] && (sum != '0);

  always_comb begin
    vote = '0;
    if (maj_mode) begin
      if (is_pos)      vote = VOTE_W'(1);
      else if (is_neg) vote = '1;
    end else if (sum > SAT_MAX) begin
      vote = SAT_MAX[VOTE_W-1:0];
    end else if (sum < SAT_MIN) begin
      vote = SAT_MIN[VOTE_W-1:0];
    end else begin
      vote = sum[VOTE_W-1:0];
    end
  end

endmodule

// File: rtl/bb_pd_decimator.sv
// Bang-bang phase-detector decimator: sums early/late decisions over a
// window of 4..32 cycles and emits one signed vote per window.
//
// Handshake: vote_valid is a one-cycle pulse with no back-pressure; vote_out
// is valid whenever vote_valid is high and holds its value between pulses.
module bb_pd_decimator #(
  parameter int VOTE_W   = cdr_pkg::VOTE_W,
  parameter int MAX_LOG2 = cdr_pkg::MAX_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              pd_valid,
  input  logic              early,
  input  logic              late,
  input  logic [1:0]        dec_sel,
  input  logic              maj_mode,
  output logic [VOTE_W-1:0] vote_out,
  output logic              vote_valid,
  output cdr_pkg::state_e   dbg_state
);

  import cdr_pkg::*;

  localparam int ACC_W = VOTE_W + 1;

  state_e                   state_q, state_d;
  logic [MAX_LOG2-1:0]      cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  dec_ratio_e               sel_q, sel_d;
  logic [VOTE_W-1:0]        vote_q;
  logic                     valid_q, valid_d;
  logic                     vote_load;

  logic signed [ACC_W-1:0]  delta;
  logic signed [ACC_W-1:0]  sum_now;
  logic [1:0]               eff_sel;
  logic [MAX_LOG2-1:0]      win_last;
  logic                     is_last;
  logic [VOTE_W-1:0]        vote_next;

  always_comb begin
    delta = '0;
    if (pd_valid && early && !late)      delta = ACC_W'(1);
    else if (pd_valid && late && !early) delta = '1;
  end

  assign sum_now = acc_q + delta;

  // The ratio is taken live on the first cycle of a window and frozen after.
  assign eff_sel  = (cnt_q == '0) ? dec_sel : sel_q;
  assign win_last = MAX_LOG2'(dec_win_len(eff_sel) - 1);
  assign is_last  = (cnt_q == win_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sel_q   <= DEC_4;
      vote_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      if (vote_load) vote_q <= vote_next;
    end
  end

  // Accumulation follows en directly so the cycle en rises is sample 0 of
  // the first window; the state register records loop activity.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    acc_d     = '0;
    sel_d     = sel_q;
    valid_d   = 1'b0;
    vote_load = 1'b0;
    case (state_q)
      ST_IDLE:  if (en)  state_d = ST_ACCUM;
      ST_ACCUM: if (!en) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
    if (en) begin
      if (cnt_q == '0) sel_d = dec_ratio_e'(dec_sel);
      if (is_last) begin
        vote_load = 1'b1;
        valid_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + MAX_LOG2'(1);
        acc_d = sum_now;
      end
    end
  end

  vote_sat #(
    .VOTE_W (VOTE_W),
    .ACC_W  (ACC_W)
  ) u_vote_sat (
    .sum      (sum_now),
    .maj_mode (maj_mode),
    .vote     (vote_next)
  );

  assign vote_out   = vote_q;
  assign vote_valid = valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bb_pd_decimator.sv
// Self-checking bench for bb_pd_decimator: windows are driven from tasks,
// expected votes and pulse cycles are queued and matched by a monitor.
module tb_bb_pd_decimator;

  import cdr_pkg::*;

  localparam int VW = 6;

  logic          clk;
  logic          reset;
  logic          en;
  logic          pd_valid;
  logic          early;
  logic          late;
  logic [1:0]    dec_sel;
  logic          maj_mode;
  logic [VW-1:0] vote_out;
  logic          vote_valid;
  state_e        dbg_state;

  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [VW-1:0] last_vote;
  logic [VW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [VW-1:0] mon_ev;
  int            mon_ec;

  bb_pd_decimator #(
    .VOTE_W   (VW),
    .MAX_LOG2 (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .pd_valid   (pd_valid),
    .early      (early),
    .late       (late),
    .dec_sel    (dec_sel),
    .maj_mode   (maj_mode),
    .vote_out   (vote_out),
    .vote_valid (vote_valid),
    .dbg_state  (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [VW-1:0] exp_vote(input int sum, input bit maj);
    int v;
    if (maj) v = (sum > 0) ? 1 : ((sum < 0) ? -1 : 0);
    else     v = (sum > 31) ? 31 : ((sum < -32) ? -32 : sum);
    return VW'(v);
  endfunction

  // Drives one window starting with en high. n_lim > 0 drives only that many
  // samples and queues nothing (used for aborted windows).
  task automatic drive_window(input int sel, input bit maj, input int pat, input int k,
                              input int chg_at, input int sel_chg, input int n_lim);
    int n;
    int sum;
    int start;
    n     = 4 << sel;
    sum   = 0;
    start = cyc;
    for (int i = 0; i < ((n_lim > 0) ? n_lim : n); i++) begin
      en       = 1'b1;
      maj_mode = maj;
      if (i == 0)            dec_sel = 2'(sel);
      else if (i == chg_at)  dec_sel = 2'(sel_chg);
      case (pat)
        0: begin pd_valid = 1'b1; early = (i < k); late = (i >= k); end
        1: begin pd_valid = 1'b1; early = 1'b1; late = 1'b1; end
        2: begin pd_valid = 1'b0; early = 1'($urandom_range(0, 1)); late = 1'($urandom_range(0, 1)); end
        default: begin
          pd_valid = 1'($urandom_range(0, 1));
          early    = 1'($urandom_range(0, 1));
          late     = 1'($urandom_range(0, 1));
        end
      endcase
      if (pd_valid && early && !late)      sum++;
      else if (pd_valid && late && !early) sum--;
      @(posedge clk); #1;
    end
    if (n_lim == 0) begin
      exp_q.push_back(exp_vote(sum, maj));
      exp_cyc_q.push_back(start + n);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0; pd_valid = 1'b0; early = 1'b0; late = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (vote_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(vote_valid), 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check("vote_out", 32'(vote_out), 32'(mon_ev));
        check("pulse_cycle", cyc, mon_ec);
        last_vote = mon_ev;
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; last_vote = '0;
    reset = 1'b1; en = 1'b1; pd_valid = 1'b1; early = 1'b1; late = 1'b0;
    dec_sel = 2'd0; maj_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vote_out", 32'(vote_out), 32'd0);
    check("reset_vote_valid", 32'(vote_valid), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    en = 1'b0;
    reset = 1'b0;
    idle_cycles(2);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // basic: N=4, all early -> +4 every 4 cycles
    for (int w = 0; w < 3; w++) drive_window(0, 0, 0, 4, -1, 0, 0);
    check("accum_state", 32'(dbg_state), 32'(ST_ACCUM));

    // saturation at N=32
    drive_window(3, 0, 0, 0, -1, 0, 0);
    drive_window(3, 0, 0, 32, -1, 0, 0);

    // majority mode and sum mode at N=8
    drive_window(1, 1, 0, 5, -1, 0, 0);
    drive_window(1, 1, 0, 4, -1, 0, 0);
    drive_window(1, 0, 0, 5, -1, 0, 0);
    drive_window(1, 1, 0, 0, -1, 0, 0);

    // null windows: both set, pd_valid low
    drive_window(0, 0, 1, 0, -1, 0, 0);
    drive_window(1, 0, 2, 0, -1, 0, 0);

    // random windows
    for (int w = 0; w < 5; w++)
      drive_window($urandom_range(0, 2), 1'($urandom_range(0, 1)), 3, 0, -1, 0, 0);

    // dec_sel 0->2 mid-window: this window stays 4, next is 16
    drive_window(0, 0, 0, 3, 2, 2, 0);
    drive_window(2, 0, 0, 16, -1, 0, 0);

    // en dropped at cycle 2 of an 8-cycle window
    drive_window(1, 0, 0, 0, -1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      check("abort_hold", 32'(vote_out), 32'(last_vote));
    end
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    drive_window(1, 0, 0, 5, -1, 0, 0);

    // reset mid-window
    drive_window(1, 0, 0, 8, -1, 0, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_vote_out", 32'(vote_out), 32'd0);
    check("midreset_valid", 32'(vote_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_vote = '0;
    drive_window(0, 0, 0, 1, -1, 0, 0);
    idle_cycles(2);
    check("final_hold", 32'(vote_out), 32'(last_vote));

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
